// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg : shared constants, pipeline-control types and helpers for the core
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] STALL  = 2'd1;
  localparam logic [1:0] FREEZE = 2'd2;
  localparam logic [1:0] FLUSH  = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_freeze;
  } pipe_ctrl_t;

  // $zero is never a real dependency, so a zero destination never matches.
  function automatic logic reg_match(input logic       use_rs,
                                     input logic [4:0] rs,
                                     input logic       use_rt,
                                     input logic [4:0] rt,
                                     input logic [4:0] x);
    return (x != REG_ZERO) && ((use_rs && (rs == x)) || (use_rt && (rt == x)));
  endfunction

  function automatic pipe_ctrl_t ctrl_decode(input logic [1:0] st);
    pipe_ctrl_t c;
    c = '0;
    case (st)
      FREEZE:  c.pipe_freeze = 1'b1;
      STALL:   c.idex_bubble = 1'b1;
      FLUSH: begin
        c.pc_write   = 1'b1;
        c.ifid_write = 1'b1;
        c.ifid_flush = 1'b1;
      end
      default: begin
        c.pc_write   = 1'b1;
        c.ifid_write = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter : saturating up-counter with synchronous clear (clear wins)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
// ----------------------------------------------------------------------------
// hazard_controller : ID-stage load-use/branch hazard stall, flush and freeze
// sequencer with saturating performance counters and a stall watchdog.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hazard_controller
  import cpu_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic             id_branch_i,
  input  logic             id_branch_taken_i,
  input  logic             id_jump_i,
  input  logic             ex_MemRead_i,
  input  logic             ex_RegWrite_i,
  input  logic [4:0]       ex_RegWriteaddr_i,
  input  logic             mem_MemRead_i,
  input  logic [4:0]       mem_RegWriteaddr_i,
  input  logic             mem_busy_i,
  input  logic             cnt_clr_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_freeze_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             wd_err_o
);

  localparam int WD_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL);

  logic [1:0]      state_q, state_d;
  logic            pend_q, pend_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_err_q, wd_err_d;

  logic       w_ex_hit;
  logic       w_mem_hit;
  logic       w_lu;
  logic       w_br;
  logic       w_hz;
  logic       w_redirect;
  logic       w_stall_inc;
  logic       w_flush_inc;
  pipe_ctrl_t w_ctrl;

  always_comb begin
    w_ex_hit   = reg_match(id_use_rs_i, id_rs_i, id_use_rt_i, id_rt_i, ex_RegWriteaddr_i);
    w_mem_hit  = reg_match(id_use_rs_i, id_rs_i, id_use_rt_i, id_rt_i, mem_RegWriteaddr_i);
    w_lu       = ex_MemRead_i & w_ex_hit;
    w_br       = id_branch_i & ((ex_RegWrite_i & w_ex_hit) | (mem_MemRead_i & w_mem_hit));
    w_hz       = w_lu | w_br;
    w_redirect = (id_branch_i & id_branch_taken_i) | id_jump_i;
  end

  // A redirect under a hazard is dropped: the branch is re-evaluated after the stall.
  always_comb begin
    state_d = RUN;
    if (mem_busy_i) begin
      state_d = FREEZE;
    end else if (w_hz) begin
      state_d = STALL;
    end else if (w_redirect || pend_q) begin
      state_d = FLUSH;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (state_d == FLUSH) begin
      pend_d = 1'b0;
    end else if (w_redirect && !w_hz && mem_busy_i) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    wd_cnt_d = '0;
    case (state_d)
      STALL:   wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
      FREEZE:  wd_cnt_d = wd_cnt_q;
      default: wd_cnt_d = '0;
    endcase
    wd_err_d = wd_err_q | (wd_cnt_d == WD_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pend_q   <= 1'b0;
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign w_stall_inc = (state_d == STALL);
  assign w_flush_inc = (state_d == FLUSH);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (w_stall_inc),
    .clr_i (cnt_clr_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (w_flush_inc),
    .clr_i (cnt_clr_i),
    .cnt_o (flush_cnt_o)
  );

  // Reset forces the RUN view at once, even while hazard inputs are still asserted.
  assign w_ctrl        = ctrl_decode(rst_n ? state_d : RUN);
  assign pc_write_o    = w_ctrl.pc_write;
  assign ifid_write_o  = w_ctrl.ifid_write;
  assign ifid_flush_o  = w_ctrl.ifid_flush;
  assign idex_bubble_o = w_ctrl.idex_bubble;
  assign pipe_freeze_o = w_ctrl.pipe_freeze;
  assign state_o       = state_q;
  assign wd_err_o      = wd_err_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ----------------------------------------------------------------------------
// tb_hazard_controller : directed stimulus against a behavioural model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hazard_controller;

  localparam int CNT_W     = 8;
  localparam int MAX_STALL = 3;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       id_rs, id_rt, ex_addr, mem_addr;
  logic             id_use_rs, id_use_rt, id_branch, id_taken, id_jump;
  logic             ex_MemRead, ex_RegWrite, mem_MemRead, mem_busy, cnt_clr;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, wd_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int nchecks = 0;
  int nerr    = 0;

  // Model state: 0=RUN 1=STALL 2=FREEZE 3=FLUSH
  int m_state = 0;
  bit m_pend  = 0;
  int m_stall = 0;
  int m_flush = 0;
  int m_consec = 0;
  bit m_wd    = 0;
  int e_nxt   = 0;
  bit e_set   = 0;

  hazard_controller #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .id_rs_i            (id_rs),
    .id_rt_i            (id_rt),
    .id_use_rs_i        (id_use_rs),
    .id_use_rt_i        (id_use_rt),
    .id_branch_i        (id_branch),
    .id_branch_taken_i  (id_taken),
    .id_jump_i          (id_jump),
    .ex_MemRead_i       (ex_MemRead),
    .ex_RegWrite_i      (ex_RegWrite),
    .ex_RegWriteaddr_i  (ex_addr),
    .mem_MemRead_i      (mem_MemRead),
    .mem_RegWriteaddr_i (mem_addr),
    .mem_busy_i         (mem_busy),
    .cnt_clr_i          (cnt_clr),
    .pc_write_o         (pc_write),
    .ifid_write_o       (ifid_write),
    .ifid_flush_o       (ifid_flush),
    .idex_bubble_o      (idex_bubble),
    .pipe_freeze_o      (pipe_freeze),
    .state_o            (state),
    .stall_cnt_o        (stall_cnt),
    .flush_cnt_o        (flush_cnt),
    .wd_err_o           (wd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [4:0] r);
    return (r != 0) && ((id_use_rs && id_rs == r) || (id_use_rt && id_rt == r));
  endfunction

  always @(negedge clk) begin
    int  nxt;
    bit  hz, redir;
    if (!rst_n) begin
      chk("rst_pc_write", pc_write, 1);
      chk("rst_ifid_write", ifid_write, 1);
      chk("rst_ifid_flush", ifid_flush, 0);
      chk("rst_idex_bubble", idex_bubble, 0);
      chk("rst_pipe_freeze", pipe_freeze, 0);
      chk("rst_state", state, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      chk("rst_wd_err", wd_err, 0);
    end else begin
      hz    = (ex_MemRead && reads(ex_addr)) ||
              (id_branch && ((ex_RegWrite && reads(ex_addr)) || (mem_MemRead && reads(mem_addr))));
      redir = (id_branch && id_taken) || id_jump;
      if (mem_busy)            nxt = 2;
      else if (hz)             nxt = 1;
      else if (redir || m_pend) nxt = 3;
      else                     nxt = 0;
      chk("pc_write", pc_write, (nxt == 0 || nxt == 3) ? 1 : 0);
      chk("ifid_write", ifid_write, (nxt == 0 || nxt == 3) ? 1 : 0);
      chk("ifid_flush", ifid_flush, (nxt == 3) ? 1 : 0);
      chk("idex_bubble", idex_bubble, (nxt == 1) ? 1 : 0);
      chk("pipe_freeze", pipe_freeze, (nxt == 2) ? 1 : 0);
      chk("state", state, m_state);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
      chk("wd_err", wd_err, m_wd);
      e_nxt = nxt;
      e_set = redir && !hz && mem_busy;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_pend = 0; m_stall = 0; m_flush = 0;
      m_consec = 0; m_wd = 0; e_nxt = 0; e_set = 0;
    end else begin
      m_state = e_nxt;
      if (e_nxt == 3)  m_pend = 0;
      else if (e_set)  m_pend = 1;
      if (cnt_clr) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (e_nxt == 1 && m_stall < CNT_MAX) m_stall++;
        if (e_nxt == 3 && m_flush < CNT_MAX) m_flush++;
      end
      if (e_nxt == 1)      m_consec++;
      else if (e_nxt != 2) m_consec = 0;
      if (m_consec >= MAX_STALL) m_wd = 1;
    end
  end

  task automatic idle();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_branch = 0; id_taken = 0; id_jump = 0;
    ex_MemRead = 0; ex_RegWrite = 0; ex_addr = 0;
    mem_MemRead = 0; mem_addr = 0; mem_busy = 0; cnt_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    ex_MemRead = 1; ex_RegWrite = 1; ex_addr = 5'd2;
    id_use_rs = 1; id_rs = 5'd2; id_use_rt = 1; id_rt = 5'd4;
  endtask

  initial begin
    idle();
    step();
    step();
    rst_n = 1;

    // load-use: one stall then RUN
    load_use();
    @(negedge clk);
    chk("t1_pc_write", pc_write, 0);
    chk("t1_idex_bubble", idex_bubble, 1);
    step();
    chk("t1_state", state, 1);
    chk("t1_stall_cnt", stall_cnt, 1);
    idle();
    step();
    chk("t1_state_run", state, 0);

    // branch behind a load: two stalls then taken flush
    cnt_clr = 1;
    step();
    idle();
    ex_MemRead = 1; ex_RegWrite = 1; ex_addr = 5'd5;
    id_branch = 1; id_taken = 1; id_use_rs = 1; id_rs = 5'd5; id_use_rt = 1; id_rt = 5'd0;
    step();
    chk("t2_stall1", stall_cnt, 1);
    ex_MemRead = 0; ex_RegWrite = 0; ex_addr = 0;
    mem_MemRead = 1; mem_addr = 5'd5;
    step();
    chk("t2_stall2", stall_cnt, 2);
    chk("t2_state", state, 1);
    mem_MemRead = 0; mem_addr = 0;
    @(negedge clk);
    chk("t2_ifid_flush", ifid_flush, 1);
    step();
    chk("t2_flush_cnt", flush_cnt, 1);
    chk("t2_stall_cnt", stall_cnt, 2);
    idle();
    step();

    // jump held through a 3-cycle freeze: exactly one flush afterwards
    id_jump = 1; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_pipe_freeze", pipe_freeze, 1);
      chk("t3_no_flush", ifid_flush, 0);
      step();
    end
    chk("t3_state_freeze", state, 2);
    mem_busy = 0;
    @(negedge clk);
    chk("t3_flush", ifid_flush, 1);
    step();
    chk("t3_flush_cnt", flush_cnt, 2);
    id_jump = 0;
    @(negedge clk);
    chk("t3_single_flush", ifid_flush, 0);
    step();

    // jump seen only at freeze start: pending flag alone delivers the flush
    id_jump = 1; mem_busy = 1;
    step();
    id_jump = 0;
    step();
    mem_busy = 0;
    @(negedge clk);
    chk("t3b_flush", ifid_flush, 1);
    step();
    @(negedge clk);
    chk("t3b_pend_cleared", ifid_flush, 0);
    step();
    chk("t3b_flush_cnt", flush_cnt, 3);

    // load into $zero never stalls
    ex_MemRead = 1; ex_addr = 5'd0; id_use_rs = 1; id_rs = 5'd0;
    @(negedge clk);
    chk("t4_pc_write", pc_write, 1);
    chk("t4_no_bubble", idex_bubble, 0);
    step();
    idle();

    // watchdog after MAX_STALL consecutive stalls, sticky afterwards
    load_use();
    step();
    step();
    chk("t5_wd_early", wd_err, 0);
    step();
    chk("t5_wd_set", wd_err, 1);
    idle();
    step();
    step();
    chk("t5_wd_sticky", wd_err, 1);

    // asynchronous reset in the middle of a stall
    load_use();
    step();
    chk("t6_state_stall", state, 1);
    #1 rst_n = 0;
    #1;
    chk("t6_pc_write", pc_write, 1);
    chk("t6_ifid_write", ifid_write, 1);
    chk("t6_idex_bubble", idex_bubble, 0);
    chk("t6_state", state, 0);
    chk("t6_stall_cnt", stall_cnt, 0);
    chk("t6_wd_err", wd_err, 0);
    step();
    rst_n = 1;
    idle();
    step();

    // saturation and clear-over-increment
    load_use();
    repeat (CNT_MAX + 5) step();
    chk("t7_saturated", stall_cnt, 32'hFF);
    cnt_clr = 1;
    step();
    chk("t7_clr_wins", stall_cnt, 0);
    cnt_clr = 0;
    idle();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and stall sequencer for the 5-stage MIPS core.
- Sits in ID alongside the forwarding unit. Detects load-use and branch-operand hazards that forwarding cannot cover, then freezes PC and IF/ID and injects ID/EX bubbles.
- Flushes IF/ID on taken branch or jump.
- Honours an external multi-cycle memory freeze, holding a pending flush across the freeze.
- Keeps saturating stall and flush counters for lab performance reporting.

Parameters:
CNT_W, 16, width of the stall and flush performance counters
MAX_STALL, 3, consecutive hazard-stall cycles before the watchdog error asserts

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  ID instruction [25:21]
id_rt  in  5  ID instruction [20:16]
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_branch  in  1  ID holds beq/bne (compared in ID)
id_branch_taken  in  1  ID comparator result, valid when id_branch
id_jump  in  1  ID holds j/jal/jr
ex_MemRead  in  1  EX instruction is a load
ex_RegWrite  in  1  EX instruction writes a register
ex_RegWriteaddr  in  5  EX destination register
mem_MemRead  in  1  MEM instruction is a load
mem_RegWriteaddr  in  5  MEM destination register
mem_busy  in  1  data/instruction memory not ready; freeze whole pipe
cnt_clr  in  1  synchronous clear of both counters
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID replaced by nop at next edge
idex_bubble  out  1  ID/EX control zeroed at next edge
pipe_freeze  out  1  all pipeline registers hold (mem_busy view)
state  out  2  current FSM state (debug)
stall_cnt  out  CNT_W  hazard-stall cycles, saturating
flush_cnt  out  CNT_W  flushes issued, saturating
wd_err  out  1  sticky watchdog error

Behaviour:
- Hazard terms, all combinational, evaluated in ID:
  - match(x) = (id_use_rs & id_rs==x) | (id_use_rt & id_rt==x), with x != 0.
  - LU = ex_MemRead & match(ex_RegWriteaddr).
  - BR = id_branch & ((ex_RegWrite & match(ex_RegWriteaddr)) | (mem_MemRead & match(mem_RegWriteaddr))).
  - hz = LU | BR.
  - A branch behind a load therefore stalls 2 cycles: cycle 1 via the ex term, cycle 2 via the mem term.
- FSM states: RUN=0, STALL=1, FREEZE=2, FLUSH=3. Reset state is RUN.
  - Any state with mem_busy=1 goes to FREEZE (highest priority).
  - Otherwise, hz=1 goes to STALL.
  - Otherwise, (redirect | pend_flush) goes to FLUSH, where redirect = (id_branch & id_branch_taken) | id_jump.
  - Otherwise, the next state is RUN.
- Outputs are Mealy, driven from the next-state decision in the same cycle:
  - FREEZE: pipe_freeze=1, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0.
  - STALL: pc_write=0, ifid_write=0, idex_bubble=1.
  - FLUSH: ifid_flush=1, pc_write=1.
  - RUN: pc_write=1, ifid_write=1, all others 0.
- Redirect seen while hz=1 is ignored, because the branch is re-evaluated after the stall.
- pend_flush register:
  - Set when redirect=1, hz=0 and mem_busy=1.
  - Cleared in the cycle the FLUSH is issued.
  - Guarantees exactly one flush per redirect across a freeze.
- Counters:
  - stall_cnt increments on each STALL cycle.
  - flush_cnt increments on each FLUSH cycle.
  - Both saturate at all-ones.
  - cnt_clr zeroes both and takes priority over increment.
- Watchdog:
  - Counts consecutive STALL cycles; FREEZE cycles hold the count, any other state resets it.
  - wd_err sets when the count reaches MAX_STALL and stays set until reset.
- Reset (async, rst_n=0, any time including mid-stall or mid-freeze):
  - state=RUN, pend_flush=0, counters=0, wd_err=0.
  - Outputs immediately read pc_write=1, ifid_write=1, others 0.

Decomposition:
- Shared package cpu_pkg:
  - FSM state encoding constants RUN/STALL/FREEZE/FLUSH.
  - REG_ZERO=5'd0.
  - Opcode constants already used by decode.
- One sub-module sat_counter (CNT_W, inc, clr), instantiated twice.

Test Plan:
- lw $2 in EX, ID add $3,$2,$4 (id_use_rs=1, id_rs=2) -> 1 cycle pc_write=0, ifid_write=0, idex_bubble=1, state=1, stall_cnt=1; next cycle RUN.
- lw $5 in EX, ID beq $5,$0 -> cycle 1 STALL (ex term); then mem_MemRead=1, mem_RegWriteaddr=5 -> cycle 2 STALL; cycle 3 taken -> ifid_flush=1, flush_cnt=1; stall_cnt=2.
- id_jump=1 with mem_busy=1 for 3 cycles -> pipe_freeze=1 for 3 cycles, no flush; 4th cycle ifid_flush=1 exactly once, pend_flush cleared.
- ex_RegWriteaddr=0 with ex_MemRead=1, id_rs=0 -> no stall, pc_write=1.
- Hazard held for 3 cycles with MAX_STALL=3 -> wd_err=1 after the third STALL cycle, and it stays set after the hazard clears.
- rst_n low mid-STALL -> outputs return to the RUN values asynchronously and counters read 0.
- stall_cnt at 16'hFFFF plus a further stall -> stays FFFF; cnt_clr=1 together with a stall -> stall_cnt=0.
